// File: rtl/pc_sequencer_if.sv
// Fetch-side control bundle for the PC sequencer: redirect requests in,
// PC state out.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             exception;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_step;
    logic             fetch_valid;
    logic             redirect_pending;
    logic             misaligned;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, exception,
        input  pc, pc_plus_step, fetch_valid, redirect_pending, misaligned
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, exception,
        output pc, pc_plus_step, fetch_valid, redirect_pending, misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential/branch/jump/exception
// selection with a one-entry redirect buffer that survives stalls.
module pc_sequencer #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       STEP         = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int unsigned       ALIGN_BITS   = 2
) (
    input logic              clk,
    input logic              reset,  // synchronous, active-low
    pc_sequencer_if.slave    bus
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    typedef enum logic [0:0] {StWarm, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_exc_q, pend_exc_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] br_tgt, jp_tgt;
    logic             br_mis, jp_mis;

    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign br_tgt       = bus.branch_target & ~ALIGN_MASK;
    assign jp_tgt       = bus.jump_target & ~ALIGN_MASK;
    assign br_mis       = |(bus.branch_target & ALIGN_MASK);
    assign jp_mis       = |(bus.jump_target & ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StWarm;
            pc_q         <= RESET_VECTOR;
            pend_tgt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_exc_q   <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_valid_q <= pend_valid_d;
            pend_exc_q   <= pend_exc_d;
            mis_q        <= mis_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_valid_d = pend_valid_q;
        pend_exc_d   = pend_exc_q;
        mis_d        = mis_q;

        unique case (state_q)
            StWarm: begin
                // First edge out of reset only arms fetch; requests are ignored.
                state_d = StRun;
            end
            StRun: begin
                if (!bus.stall) begin
                    if (bus.exception) begin
                        pc_d = EXC_VECTOR;
                    end else if (pend_valid_q) begin
                        pc_d = pend_tgt_q;
                    end else if (bus.branch_taken) begin
                        pc_d  = br_tgt;
                        mis_d = mis_q | br_mis;
                    end else if (bus.jump) begin
                        pc_d  = jp_tgt;
                        mis_d = mis_q | jp_mis;
                    end else begin
                        pc_d = pc_plus_step;
                    end
                    pend_valid_d = 1'b0;
                    pend_exc_d   = 1'b0;
                end else begin
                    // A buffered exception is never displaced by later control flow.
                    if (bus.exception) begin
                        pend_tgt_d   = EXC_VECTOR;
                        pend_valid_d = 1'b1;
                        pend_exc_d   = 1'b1;
                    end else if (!pend_exc_q) begin
                        if (bus.branch_taken) begin
                            pend_tgt_d   = br_tgt;
                            pend_valid_d = 1'b1;
                            mis_d        = mis_q | br_mis;
                        end else if (bus.jump) begin
                            pend_tgt_d   = jp_tgt;
                            pend_valid_d = 1'b1;
                            mis_d        = mis_q | jp_mis;
                        end
                    end
                end
            end
            default: state_d = StWarm;
        endcase
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus_step     = pc_plus_step;
    assign bus.fetch_valid      = (state_q == StRun);
    assign bus.redirect_pending = pend_valid_q;
    assign bus.misaligned       = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run checked
// against a behavioural model of the fetch PC.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h0000_0080;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(32)) bus ();

    pc_sequencer #(
        .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .ALIGN_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] tgt;
        bit          is_exc;
    } pend_t;

    logic [31:0] m_pc;
    bit          m_fv;
    bit          m_mis;
    pend_t       m_pend[$];

    // Drive one cycle of inputs, clock it, advance the model, sample 1ns later.
    task automatic cycle(input logic rs, input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic ex);
        pend_t e;
        reset = rs;
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = bt;
        bus.jump = jp;
        bus.jump_target = jt;
        bus.exception = ex;
        @(posedge clk);
        if (!rs) begin
            m_pc = 32'h0; m_fv = 0; m_mis = 0; m_pend.delete();
        end else if (!m_fv) begin
            m_fv = 1;
        end else if (!st) begin
            if (ex) m_pc = EXC;
            else if (m_pend.size() > 0) m_pc = m_pend[0].tgt;
            else if (br) begin m_pc = {bt[31:2], 2'b00}; if (bt[1:0] != 0) m_mis = 1; end
            else if (jp) begin m_pc = {jt[31:2], 2'b00}; if (jt[1:0] != 0) m_mis = 1; end
            else m_pc = m_pc + 32'd4;
            m_pend.delete();
        end else if (ex) begin
            m_pend.delete();
            e.tgt = EXC; e.is_exc = 1; m_pend.push_back(e);
        end else if ((br || jp) && !(m_pend.size() > 0 && m_pend[0].is_exc)) begin
            e.tgt = br ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
            e.is_exc = 0;
            if ((br ? bt[1:0] : jt[1:0]) != 0) m_mis = 1;
            m_pend.delete();
            m_pend.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1);
            n_checks++;
            if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state got pc=%h fv=%b want pc=0 fv=0", bus.pc, bus.fetch_valid);
            end
        end
        // Warm-up edge: requests are ignored, fetch becomes valid at RESET_VECTOR.
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b1 || bus.pc_plus_step !== 32'h4) begin
            n_fail++;
            $display("FAIL warmup got pc=%h fv=%b pps=%h want pc=0 fv=1 pps=4",
                     bus.pc, bus.fetch_valid, bus.pc_plus_step);
        end
        for (int i = 1; i <= 2; i++) begin
            idle();
            n_checks++;
            if (bus.pc !== 32'(4 * i) || bus.pc_plus_step !== 32'(4 * i + 4)) begin
                n_fail++;
                $display("FAIL sequential got pc=%h pps=%h want pc=%h", bus.pc, bus.pc_plus_step,
                         32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        n_checks++;
        if (bus.pc !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_jump got=%h want=fffffff8", bus.pc);
        end
        idle();
        n_checks++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus_step !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_top got pc=%h pps=%h want pc=fffffffc pps=0", bus.pc, bus.pc_plus_step);
        end
        idle();
        n_checks++;
        if (bus.pc !== 32'h0 || bus.misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_zero got pc=%h mis=%b want pc=0 mis=0", bus.pc, bus.misaligned);
        end
    endtask

    task automatic test_priority();
        cycle(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
        n_checks++;
        if (bus.pc !== 32'h200) begin
            n_fail++; $display("FAIL branch_over_jump got=%h want=200", bus.pc);
        end
    endtask

    task automatic test_stall_latest();
        cycle(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.pc !== 32'h200 || bus.redirect_pending !== 1'b1 || bus.fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold got pc=%h pend=%b fv=%b want pc=200 pend=1 fv=1",
                     bus.pc, bus.redirect_pending, bus.fetch_valid);
        end
        idle();
        n_checks++;
        if (bus.pc !== 32'h500 || bus.redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got pc=%h pend=%b want pc=500 pend=0",
                     bus.pc, bus.redirect_pending);
        end
    endtask

    task automatic test_stall_exception();
        cycle(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.pc !== EXC || bus.redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_pending got pc=%h pend=%b want pc=80 pend=0", bus.pc, bus.redirect_pending);
        end
        idle();
        n_checks++;
        if (bus.pc !== 32'h84) begin
            n_fail++; $display("FAIL exc_resume got=%h want=84", bus.pc);
        end
    endtask

    task automatic test_misaligned();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
        n_checks++;
        if (bus.pc !== 32'h100 || bus.misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_jump got pc=%h mis=%b want pc=100 mis=1", bus.pc, bus.misaligned);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
        idle();
        n_checks++;
        if (bus.misaligned !== 1'b1 || bus.pc !== 32'h804) begin
            n_fail++;
            $display("FAIL misaligned_sticky got pc=%h mis=%b want pc=804 mis=1", bus.pc, bus.misaligned);
        end
    endtask

    task automatic test_reset_pending();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
        n_checks++;
        if (bus.redirect_pending !== 1'b1) begin
            n_fail++; $display("FAIL rp_capture got pend=%b want 1", bus.redirect_pending);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.pc !== 32'h0 || bus.redirect_pending !== 1'b0 || bus.misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_reset got pc=%h pend=%b mis=%b want pc=0 pend=0 mis=0",
                     bus.pc, bus.redirect_pending, bus.misaligned);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();
        n_checks++;
        if (bus.pc !== 32'h4 || bus.redirect_pending !== 1'b0 || bus.fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_release got pc=%h pend=%b fv=%b want pc=4 pend=0 fv=1",
                     bus.pc, bus.redirect_pending, bus.fetch_valid);
        end
    endtask

    task automatic test_random();
        logic rs, st, br, jp, ex;
        logic [31:0] bt, jt;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 79) != 0);
            st = ($urandom_range(0, 9) < 4);
            br = ($urandom_range(0, 5) == 0);
            jp = ($urandom_range(0, 5) == 0);
            ex = ($urandom_range(0, 19) == 0);
            bt = $urandom();
            jt = $urandom();
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            cycle(rs, st, br, bt, jp, jt, ex);
            n_checks++;
            if (bus.pc !== m_pc || bus.pc_plus_step !== m_pc + 32'd4 || bus.fetch_valid !== m_fv ||
                bus.redirect_pending !== (m_pend.size() > 0) || bus.misaligned !== m_mis) begin
                n_fail++;
                $display("FAIL random[%0d] got pc=%h pps=%h fv=%b pend=%b mis=%b want pc=%h fv=%b pend=%b mis=%b",
                         i, bus.pc, bus.pc_plus_step, bus.fetch_valid, bus.redirect_pending,
                         bus.misaligned, m_pc, m_fv, (m_pend.size() > 0), m_mis);
            end
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        bus.jump = 1'b0;
        bus.jump_target = '0;
        bus.exception = 1'b0;
        m_pc = 32'h0;
        m_fv = 0;
        m_mis = 0;
        test_reset();
        test_wrap();
        test_priority();
        test_stall_latest();
        test_stall_exception();
        test_misaligned();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
